// File: rtl/status_feeder.sv
// Serial-to-nibble feeder for status_detect: shifts in 4 bits, presents a..d, then strobes go.
// Optional even-parity check on a 5th serial bit is enabled with `define STATUS_FEEDER_PARITY_EN.
module status_feeder #(
    parameter int GO_HOLD   = 4,
    parameter int MSB_FIRST = 1,
    parameter int TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       busy,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       go,
    output logic [7:0] nib_count,
    output logic       err
);

`ifdef STATUS_FEEDER_PARITY_EN
    localparam logic [2:0] NBITS = 3'd5;
`else
    localparam logic [2:0] NBITS = 3'd4;
`endif
    localparam logic [2:0] LAST_BIT  = NBITS - 3'd1;
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [7:0] HOLD_LAST = 8'(GO_HOLD);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SETUP,
        GO_ST
    } state_t;

    state_t     state;
    logic [3:0] shreg;
    logic [3:0] shreg_nxt;
    logic [2:0] bit_cnt;
    logic [7:0] timer;
    logic [7:0] hold_cnt;
    logic       accept;

    assign accept = bit_valid && !busy;

    // Both bit orders leave the nibble as {a,b,c,d} in shreg[3:0].
    always_comb begin
        shreg_nxt = shreg;
        if (MSB_FIRST != 0) shreg_nxt = {shreg[2:0], bit_in};
        else                shreg_nxt = {bit_in, shreg[3:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= 4'd0;
            bit_cnt   <= 3'd0;
            timer     <= 8'd0;
            hold_cnt  <= 8'd0;
            busy      <= 1'b0;
            go        <= 1'b0;
            a         <= 1'b0;
            b         <= 1'b0;
            c         <= 1'b0;
            d         <= 1'b0;
            nib_count <= 8'd0;
`ifdef STATUS_FEEDER_PARITY_EN
            err       <= 1'b0;
`endif
        end else begin
`ifdef STATUS_FEEDER_PARITY_EN
            err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= shreg_nxt;
                        bit_cnt <= 3'd1;
                        timer   <= 8'd0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        timer <= 8'd0;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= 3'd0;
`ifdef STATUS_FEEDER_PARITY_EN
                            // Final bit is the parity bit; shreg already holds the nibble.
                            if ((^shreg) == bit_in) begin
                                {a, b, c, d} <= shreg;
                                busy         <= 1'b1;
                                state        <= SETUP;
                            end else begin
                                err   <= 1'b1;
                                state <= IDLE;
                            end
`else
                            {a, b, c, d} <= shreg_nxt;
                            busy         <= 1'b1;
                            state        <= SETUP;
`endif
                        end else begin
                            shreg   <= shreg_nxt;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else if (timer == TO_LAST) begin
                        timer   <= 8'd0;
                        bit_cnt <= 3'd0;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                SETUP: begin
                    go        <= 1'b1;
                    hold_cnt  <= 8'd1;
                    nib_count <= nib_count + 8'd1;
                    state     <= GO_ST;
                end
                GO_ST: begin
                    if (hold_cnt == HOLD_LAST) begin
                        go       <= 1'b0;
                        busy     <= 1'b0;
                        hold_cnt <= 8'd0;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef STATUS_FEEDER_PARITY_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_status_feeder.sv
// Scoreboard bench for status_feeder: stimulus queues expected deliveries, a negedge monitor
// checks nibble, setup stability, nib_count, go latency and go width on every go rise.
module tb_status_feeder;
    localparam int GO_HOLD = 4;
`ifdef STATUS_FEEDER_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       busy, a, b, c, d, go, err;
    logic [7:0] nib_count;

    status_feeder #(.GO_HOLD(GO_HOLD), .MSB_FIRST(1), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .busy(busy), .a(a), .b(b), .c(c), .d(d), .go(go),
        .nib_count(nib_count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] nib;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         err_seen = 0;
    int         exp_err = 0;
    logic [7:0] exp_cnt = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor
    logic       go_prev = 1'b0;
    int         go_len = 0;
    logic [3:0] abcd_prev = 4'd0;
    exp_t       e;

    always @(negedge clk) begin
        if (!rst_n) begin
            go_prev = 1'b0;
            go_len  = 0;
        end else begin
            if (err) err_seen++;
            if (go && !go_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_go", 32'(go), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("nibble", 32'({a, b, c, d}), 32'(e.nib));
                    chk("setup_stable", 32'(abcd_prev), 32'(e.nib));
                    chk("nib_count", 32'(nib_count), 32'(e.cnt));
                    chk("go_latency", 32'(cyc), 32'(e.cyc));
                end
            end
            if (go) go_len++;
            else if (go_prev) begin
                chk("go_width", 32'(go_len), 32'(GO_HOLD));
                go_len = 0;
            end
            go_prev = go;
        end
        abcd_prev = {a, b, c, d};
    end

    task automatic drive_bit(input logic bv);
        @(negedge clk);
        bit_in    = bv;
        bit_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bit_in    = 1'b0;
            bit_valid = 1'b0;
        end
    endtask

    // Call in the same timestep the final bit is driven.
    task automatic expect_nib(input logic [3:0] nib);
        exp_t x;
        exp_cnt = exp_cnt + 8'd1;
        x.nib = nib;
        x.cnt = exp_cnt;
        x.cyc = cyc + 2;
        sb.push_back(x);
    endtask

    task automatic send_bits(input logic [3:0] nib);
        for (int i = 3; i >= 0; i--) drive_bit(nib[i]);
`ifdef STATUS_FEEDER_PARITY_EN
        drive_bit(^nib);
`endif
    endtask

    task automatic send_nib(input logic [3:0] nib);
        send_bits(nib);
        expect_nib(nib);
        idle(GO_HOLD + 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_go, hi_busy, waited;
        logic [3:0] held;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_go", 32'(go), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_abcd", 32'({a, b, c, d}), 32'(0));
        chk("rst_count", 32'(nib_count), 32'(0));
        rst_n = 1'b1;

        hi_go = 0;
        hi_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (go) hi_go++;
            if (busy) hi_busy++;
        end
        chk("idle_go_cycles", 32'(hi_go), 32'(0));
        chk("idle_busy_cycles", 32'(hi_busy), 32'(0));

        // Single nibble 1000
        send_nib(4'b1000);

        // 2 bits then 15 idle cycles: partial kept, completes as 0011
        drive_bit(1'b0);
        drive_bit(1'b0);
        idle(15);
        drive_bit(1'b1);
        drive_bit(1'b1);
`ifdef STATUS_FEEDER_PARITY_EN
        drive_bit(1'b0);
`endif
        expect_nib(4'b0011);
        idle(GO_HOLD + 2);

        // 2 bits then 16 idle cycles: partial dropped, a..d unchanged
        drive_bit(1'b0);
        drive_bit(1'b0);
        idle(16);
        chk("timeout_abcd_hold", 32'({a, b, c, d}), 32'(4'b0011));
        chk("timeout_no_busy", 32'(busy), 32'(0));
        send_nib(4'b1111);

        // Continuous bit_valid: 0101 framed by junk 1s that arrive while busy
        for (int n = 0; n < 256; n++) begin
            drive_bit(1'b0);
            drive_bit(1'b1);
            drive_bit(1'b0);
            drive_bit(1'b1);
`ifdef STATUS_FEEDER_PARITY_EN
            drive_bit(1'b0);
`endif
            expect_nib(4'b0101);
            for (int j = 0; j < GO_HOLD + 1; j++) drive_bit(1'b1);
        end
        idle(3);
        chk("wrap_count", 32'(nib_count), 32'(exp_cnt));

`ifdef STATUS_FEEDER_PARITY_EN
        // Bad parity: err pulse, no delivery
        held = {a, b, c, d};
        for (int i = 3; i >= 0; i--) drive_bit(held[0] ^ held[0] ^ (i == 3));
        drive_bit(1'b0);
        @(negedge clk);
        bit_valid = 1'b0;
        chk("par_err_pulse", 32'(err), 32'(1));
        chk("par_no_busy", 32'(busy), 32'(0));
        @(negedge clk);
        chk("par_err_one_cycle", 32'(err), 32'(0));
        chk("par_abcd_hold", 32'({a, b, c, d}), 32'(held));
        chk("par_count_hold", 32'(nib_count), 32'(exp_cnt));
        exp_err = exp_err + 1;
        idle(4);
        send_nib(4'b1000);
`else
        held = 4'd0;
`endif

        // Reset during the second go cycle
        send_bits(4'b0110);
        expect_nib(4'b0110);
        waited = 0;
        @(negedge clk);
        bit_valid = 1'b0;
        while (!go && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("go_seen_before_reset", 32'(go), 32'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_go", 32'(go), 32'(0));
        chk("async_rst_busy", 32'(busy), 32'(0));
        chk("async_rst_count", 32'(nib_count), 32'(0));
        chk("async_rst_abcd", 32'({a, b, c, d}), 32'(0));
        exp_cnt = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send_nib(4'b0110);
        idle(4);

        chk("scoreboard_empty", 32'(sb.size()), 32'(0));
        chk("err_pulses", 32'(err_seen), 32'(exp_err));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
